// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// The default pattern matches the 11000 sequence detectors it drives.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

    localparam int          PAT_W_DEF   = 5;
    localparam int          CNT_W_DEF   = 8;
    localparam int          GAP_W_DEF   = 4;
    localparam logic [4:0]  DEF_PATTERN = 5'b11000;

    // Bit-index width, kept at least 1 so a 1-bit pattern still has a legal index.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/stream bundle of seq_pattern_tx: the master drives configuration,
// the slave (transmitter) returns status and the serial stream.
interface seq_pattern_tx_if
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
);
    logic             start;
    logic             use_default;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic [GAP_W-1:0] gap;
    logic             abort;

    logic             ready;
    logic             busy;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             done;
    logic [CNT_W-1:0] pat_count;

    modport master (
        output start, use_default, pattern, repeat_n, gap, abort,
        input  ready, busy, sout, sout_valid, frame_start, done, pat_count
    );

    modport slave (
        input  start, use_default, pattern, repeat_n, gap, abort,
        output ready, busy, sout, sout_valid, frame_start, done, pat_count
    );
endinterface

// File: rtl/seq_pattern_tx_piso_shift_reg.sv
// Parallel-in serial-out shift register: load wins over shift, bits leave MSB-first.
module piso_shift_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);
    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a captured pattern MSB-first, optionally
// separated by idle gaps. All outputs decode registered state only.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W       = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(DEF_PATTERN),
    parameter int               CNT_W       = CNT_W_DEF,
    parameter int               GAP_W       = GAP_W_DEF
) (
    input  logic clk,
    input  logic rst,
    seq_pattern_tx_if.slave tx_if
);
    localparam int                IDX_W    = idx_width(PAT_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PAT_W - 1);

    tx_state_e        state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] rep_left_q, rep_left_d;
    logic [CNT_W-1:0] pat_count_q, pat_count_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [PAT_W-1:0] pat_q, pat_d;

    logic             sr_load, sr_shift, sr_msb;
    logic [PAT_W-1:0] sr_data;
    logic [PAT_W-1:0] start_pat;

    assign start_pat = tx_if.use_default ? PAT_DEFAULT : tx_if.pattern;

    piso_shift_reg #(.W(PAT_W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_data),
        .msb_o   (sr_msb)
    );

    // Abort has priority over the end-of-pattern bookkeeping, so a frame cut
    // on its final bit is never counted as completed.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        rep_left_d  = rep_left_q;
        pat_count_d = pat_count_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        pat_d       = pat_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_data     = pat_q;

        unique case (state_q)
            IDLE: begin
                if (tx_if.start && !tx_if.abort) begin
                    pat_d       = start_pat;
                    sr_data     = start_pat;
                    sr_load     = 1'b1;
                    rep_left_d  = (tx_if.repeat_n == '0) ? CNT_W'(1) : tx_if.repeat_n;
                    gap_len_d   = tx_if.gap;
                    pat_count_d = '0;
                    bit_idx_d   = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (tx_if.abort) begin
                    bit_idx_d = '0;
                    state_d   = IDLE;
                end else if (bit_idx_q == LAST_IDX) begin
                    pat_count_d = pat_count_q + 1'b1;
                    rep_left_d  = rep_left_q - 1'b1;
                    sr_load     = 1'b1;
                    bit_idx_d   = '0;
                    if (rep_left_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else if (gap_len_q == '0) begin
                        state_d = SHIFT;
                    end else begin
                        gap_cnt_d = gap_len_q;
                        state_d   = GAP;
                    end
                end else begin
                    sr_shift  = 1'b1;
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            GAP: begin
                if (tx_if.abort) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            rep_left_q  <= '0;
            pat_count_q <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            pat_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            rep_left_q  <= rep_left_d;
            pat_count_q <= pat_count_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            pat_q       <= pat_d;
        end
    end

    assign tx_if.ready       = (state_q == IDLE);
    assign tx_if.busy        = (state_q == SHIFT) || (state_q == GAP);
    assign tx_if.sout        = (state_q == SHIFT) && sr_msb;
    assign tx_if.sout_valid  = (state_q == SHIFT);
    assign tx_if.frame_start = (state_q == SHIFT) && (bit_idx_q == '0);
    assign tx_if.done        = (state_q == DONE);
    assign tx_if.pat_count   = pat_count_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: expected stream bits are queued when a run
// is launched and retired as valid bits appear; an 11000 detector model rides along.
module tb_seq_pattern_tx;

    typedef struct {
        logic bitVal;
        logic fs;
        int   idx;
    } sbEntry_t;

    logic clk;
    logic rst;

    seq_pattern_tx_if #(.PAT_W(5), .CNT_W(8), .GAP_W(4)) bus ();

    seq_pattern_tx dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sbEntry_t   sbQ[$];
    int         passCount  = 0;
    int         totalCount = 0;
    int         doneCnt, doneAt, gapCycles, cycleIdx, detCount;
    logic [4:0] detHist;
    logic [4:0] defPat = 5'b11000;
    logic [4:0] altPat = 5'b10110;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic pushBits(input logic [4:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            sbEntry_t e;
            e.bitVal = pat[4-i];
            e.fs     = (i == 0);
            e.idx    = i;
            sbQ.push_back(e);
        end
    endtask

    task automatic pushFrames(input logic [4:0] pat, input int reps);
        for (int r = 0; r < reps; r++) pushBits(pat, 5);
    endtask

    task automatic clearRun();
        doneCnt   = 0;
        doneAt    = -1;
        gapCycles = 0;
        cycleIdx  = 0;
        detCount  = 0;
        detHist   = '0;
    endtask

    task automatic applyStimulus(input logic useDef, input logic [4:0] pat, input logic [7:0] rep, input logic [3:0] gapLen);
        bus.use_default = useDef;
        bus.pattern     = pat;
        bus.repeat_n    = rep;
        bus.gap         = gapLen;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
    endtask

    // One observation at a negedge: retire a queued bit or check an idle gap cycle.
    task automatic sampleCycle();
        sbEntry_t e;
        if (bus.sout_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_bit", sbQ.size(), 1);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sout", bus.sout, e.bitVal);
                checkOutput("frame_start", bus.frame_start, e.fs);
                checkOutput("busy_in_shift", bus.busy, 1'b1);
                detHist = {detHist[3:0], bus.sout};
                if (detHist == 5'b11000) begin
                    detCount++;
                    checkOutput("det_align", e.idx, 4);
                end
            end
        end else if (bus.busy) begin
            gapCycles++;
            checkOutput("gap_sout", bus.sout, 1'b0);
        end
        if (bus.done) begin
            doneCnt++;
            doneAt = cycleIdx;
        end
        cycleIdx++;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && !bus.ready; c++) begin
            sampleCycle();
            @(negedge clk);
        end
        checkOutput("ready_after_run", bus.ready, 1'b1);
        checkOutput("sb_empty", sbQ.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, bus.ready, 1'b1);
        checkOutput({tag, "_busy"}, bus.busy, 1'b0);
        checkOutput({tag, "_sout"}, bus.sout, 1'b0);
        checkOutput({tag, "_valid"}, bus.sout_valid, 1'b0);
        checkOutput({tag, "_fs"}, bus.frame_start, 1'b0);
        checkOutput({tag, "_done"}, bus.done, 1'b0);
        checkOutput({tag, "_count"}, bus.pat_count, 8'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.use_default = 1'b0;
        bus.pattern     = '0;
        bus.repeat_n    = '0;
        bus.gap         = '0;
        bus.abort       = 1'b0;
        clearRun();
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // start together with abort in IDLE must be ignored
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput("start_abort_ready", bus.ready, 1'b1);
        checkOutput("start_abort_busy", bus.busy, 1'b0);

        // single default frame
        clearRun();
        pushFrames(defPat, 1);
        applyStimulus(1'b1, 5'b00000, 8'd1, 4'd0);
        drain(30);
        checkOutput("t1_done_cnt", doneCnt, 1);
        checkOutput("t1_done_at", doneAt, 5);
        checkOutput("t1_pat_count", bus.pat_count, 8'd1);

        // explicit pattern, three back-to-back frames
        clearRun();
        pushFrames(altPat, 3);
        applyStimulus(1'b0, altPat, 8'd3, 4'd0);
        drain(60);
        checkOutput("t2_done_cnt", doneCnt, 1);
        checkOutput("t2_done_at", doneAt, 15);
        checkOutput("t2_gap_cycles", gapCycles, 0);
        checkOutput("t2_pat_count", bus.pat_count, 8'd3);

        // two default frames with a two-cycle gap
        clearRun();
        pushFrames(defPat, 2);
        applyStimulus(1'b1, 5'b00000, 8'd2, 4'd2);
        drain(60);
        checkOutput("t3_gap_cycles", gapCycles, 2);
        checkOutput("t3_done_at", doneAt, 12);
        checkOutput("t3_done_cnt", doneCnt, 1);
        checkOutput("t3_pat_count", bus.pat_count, 8'd2);

        // repeat_n=0 sends one frame; a start mid-frame is ignored
        clearRun();
        pushFrames(defPat, 1);
        applyStimulus(1'b1, 5'b00000, 8'd0, 4'd0);
        for (int c = 0; c < 2; c++) begin
            sampleCycle();
            @(negedge clk);
        end
        bus.use_default = 1'b0;
        bus.pattern     = altPat;
        bus.repeat_n    = 8'd3;
        bus.start       = 1'b1;
        sampleCycle();
        @(negedge clk);
        bus.start = 1'b0;
        drain(40);
        checkOutput("t4_done_cnt", doneCnt, 1);
        checkOutput("t4_pat_count", bus.pat_count, 8'd1);
        for (int c = 0; c < 3; c++) begin
            checkOutput("t4_no_second_frame", bus.sout_valid, 1'b0);
            @(negedge clk);
        end

        // abort on the third bit of frame 2 of a four-frame run
        clearRun();
        pushFrames(defPat, 1);
        pushBits(defPat, 3);
        applyStimulus(1'b1, 5'b00000, 8'd4, 4'd0);
        for (int c = 0; c < 7; c++) begin
            sampleCycle();
            @(negedge clk);
        end
        sampleCycle();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("t5_ready", bus.ready, 1'b1);
        checkOutput("t5_valid", bus.sout_valid, 1'b0);
        checkOutput("t5_busy", bus.busy, 1'b0);
        checkOutput("t5_done", bus.done, 1'b0);
        checkOutput("t5_pat_count", bus.pat_count, 8'd1);
        checkOutput("t5_sb_empty", sbQ.size(), 0);
        @(negedge clk);
        checkOutput("t5_no_late_done", bus.done, 1'b0);
        checkOutput("t5_done_cnt", doneCnt, 0);

        // reset in the middle of a gap
        clearRun();
        pushFrames(defPat, 1);
        applyStimulus(1'b1, 5'b00000, 8'd2, 4'd3);
        for (int c = 0; c < 6; c++) begin
            sampleCycle();
            @(negedge clk);
        end
        checkOutput("t6_in_gap_busy", bus.busy, 1'b1);
        checkOutput("t6_in_gap_valid", bus.sout_valid, 1'b0);
        checkOutput("t6_count_before", bus.pat_count, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("t6_rst");
        checkOutput("t6_done_cnt", doneCnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // loopback into an overlapping 11000 detector model
        clearRun();
        pushFrames(defPat, 3);
        applyStimulus(1'b1, 5'b00000, 8'd3, 4'd0);
        drain(60);
        checkOutput("t7_detections", detCount, 3);
        checkOutput("t7_done_cnt", doneCnt, 1);
        checkOutput("t7_pat_count", bus.pat_count, 8'd3);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the stimulus-side counterpart of the team's Moore sequence detectors.
- Loads a PAT_W-bit pattern (default 11000) and shifts it out MSB-first on a 1-bit stream, one bit per clk.
- Supports a programmable repeat count, with optional idle gaps or back-to-back (overlapping-friendly) repetition.
- Feeds detector blocks in benches and in loopback self-test.

Parameters:
PAT_W, 5, pattern length in bits
PAT_DEFAULT, 5'b11000, pattern captured when use_default=1 at start
CNT_W, 8, width of repeat_n and pat_count
GAP_W, 4, width of gap

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin transmission; sampled only when ready=1
use_default  in  1  at start: 1 = send PAT_DEFAULT, 0 = send pattern
pattern  in  PAT_W  pattern to send, captured at start
repeat_n  in  CNT_W  number of pattern transmissions; 0 is treated as 1
gap  in  GAP_W  idle cycles inserted between repetitions (0 = back-to-back)
abort  in  1  terminate the current transmission
ready  out  1  1 when in IDLE and able to accept start
busy  out  1  1 in SHIFT or GAP
sout  out  1  serial data bit
sout_valid  out  1  1 when sout carries a pattern bit
frame_start  out  1  1 on the first bit of each pattern instance
done  out  1  one-cycle pulse after the final bit of a non-aborted run
pat_count  out  CNT_W  number of patterns fully emitted in the current or last run

Behaviour:
- FSM states: IDLE, SHIFT, GAP, DONE. All outputs are Moore, decoded from registered state, shift register, bit index and counters. No input-to-output combinational path.
- Reset (rst=1 at a clk edge): state=IDLE, shift reg=0, bit_idx=0, rep_left=0, gap_cnt=0, pat_count=0.
  - Resulting outputs: ready=1, busy=0, sout=0, sout_valid=0, frame_start=0, done=0.
  - Reset takes effect from any state, including mid-frame; no done pulse is produced.
- IDLE:
  - On an edge with start=1 and abort=0: capture the pattern (PAT_DEFAULT if use_default else pattern), rep_left=max(repeat_n,1), gap, clear pat_count, go to SHIFT with bit_idx=0.
  - start=1 together with abort=1 in IDLE: ignored.
- SHIFT:
  - sout = shift reg MSB, sout_valid=1, frame_start=(bit_idx==0).
  - Each edge shifts left by one and increments bit_idx.
  - Latency: start sampled at edge T puts bit PAT_W-1 on sout during cycle T..T+1. The last bit of the first pattern appears in cycle T+PAT_W-1..T+PAT_W.
- End of pattern (edge leaving bit_idx==PAT_W-1):
  - pat_count+1, rep_left-1, shift reg reloaded from the captured pattern.
  - If rep_left was 1: go to DONE.
  - Else if gap==0: stay in SHIFT with bit_idx=0, no bubble between patterns.
  - Else: go to GAP with gap_cnt=gap.
- GAP:
  - sout=0, sout_valid=0, busy=1.
  - gap_cnt decrements each edge; at gap_cnt==1 go to SHIFT, bit_idx=0.
  - Exactly `gap` idle cycles are inserted.
- DONE: done=1, ready=0, busy=0 for exactly one cycle, then IDLE. pat_count holds until the next accepted start.
- abort=1 at an edge in SHIFT or GAP: next state IDLE, no done pulse, pat_count keeps completed patterns only (a partial pattern is not counted).
- start while busy or in DONE: ignored, no effect on the captured configuration.
- Width rules: repeat_n ≤ 2^CNT_W−1 so pat_count never wraps. bit_idx width = clog2(PAT_W). The pattern is held in a separate capture register so a repeat never depends on live pattern input.

Decomposition:
- Package seq_tx_pkg: state enum (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2, DONE=2'd3), PAT_DEFAULT constant, CNT_W/GAP_W defaults.
- One sub-module: piso_shift_reg (parallel load, shift-left, MSB out, load/shift enables). The FSM, counters and output decode stay in the top.

Test Plan:
- Reset, then use_default=1, repeat_n=1, gap=0, start at edge T -> sout=1,1,0,0,0 with sout_valid=1 over cycles T+1..T+5; frame_start only in the first of these; done=1 at T+6; pat_count=1; ready=1 at T+7.
- pattern=5'b10110, use_default=0, repeat_n=3, gap=0 -> 15 contiguous valid bits 101101011010110; frame_start on bits 1, 6, 11; pat_count=3; single done pulse.
- Default pattern, repeat_n=2, gap=2 -> 11000, two cycles of sout_valid=0/sout=0, 11000, then done; busy=1 throughout.
- repeat_n=0 -> exactly one 11000 frame, pat_count=1. A start pulse issued during that frame is ignored: no second frame, captured config unchanged.
- repeat_n=4: abort on the 3rd bit of frame 2 -> IDLE next cycle, no done, pat_count=1, sout_valid=0. Separately, rst mid-GAP -> all outputs at reset values the next cycle.
- Loopback into the 11000 overlapping detector: repeat_n=3, gap=0 -> detector output asserted once per frame (3 detections), aligned to each frame's final 0.
